// File: rtl/intersection_controller_if.sv
// Signal bundle between the intersection controller and its environment.
//   car_ew      : east-west vehicle waiting (level)
//   ped_req     : pedestrian button pulse
//   emerg       : emergency all-red override (level)
//   ns_light    : north-south light, 00 red / 01 yellow / 10 green
//   ew_light    : east-west light, same encoding
//   walk        : pedestrian walk indication
//   state       : current controller state code
//   ped_pending : latched pedestrian request not yet served
// master drives the request inputs; slave is the controller.
interface intersection_controller_if;
    logic       car_ew;
    logic       ped_req;
    logic       emerg;
    logic [1:0] ns_light;
    logic [1:0] ew_light;
    logic       walk;
    logic [2:0] state;
    logic       ped_pending;

    modport master (
        output car_ew, ped_req, emerg,
        input  ns_light, ew_light, walk, state, ped_pending
    );

    modport slave (
        input  car_ew, ped_req, emerg,
        output ns_light, ew_light, walk, state, ped_pending
    );
endinterface

// File: rtl/intersection_controller.sv
// Two-way intersection sequencer: timed NS/EW phases, EW car sensor,
// latched pedestrian request with a walk phase, emergency all-red override.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   io    : intersection_controller_if.slave (requests in, lights/status out)
// Lights are registered alongside the state so they always match its decode.
module intersection_controller #(
    parameter int GREEN_CYC  = 8,
    parameter int YELLOW_CYC = 2,
    parameter int ALLRED_CYC = 1,
    parameter int PED_CYC    = 4,
    parameter int CNT_W      = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    intersection_controller_if.slave  io
);

    localparam logic [1:0] L_RED = 2'b00;
    localparam logic [1:0] L_YEL = 2'b01;
    localparam logic [1:0] L_GRN = 2'b10;

    typedef enum logic [2:0] {
        S_NS_G  = 3'd0,
        S_NS_Y  = 3'd1,
        S_ALL_R = 3'd2,
        S_EW_G  = 3'd3,
        S_EW_Y  = 3'd4,
        S_WALK  = 3'd5,
        S_EMRG  = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   timer_q, timer_d;
    logic               dir_ew_q, dir_ew_d;   // direction served after the next all-red
    logic               ped_q, ped_d;
    logic [1:0]         ns_q, ew_q;
    logic               walk_q;
    logic               expired;

    assign expired = (timer_q == '0);

    function automatic logic [1:0] ns_of(state_t s);
        case (s)
            S_NS_G:  return L_GRN;
            S_NS_Y:  return L_YEL;
            default: return L_RED;
        endcase
    endfunction

    function automatic logic [1:0] ew_of(state_t s);
        case (s)
            S_EW_G:  return L_GRN;
            S_EW_Y:  return L_YEL;
            default: return L_RED;
        endcase
    endfunction

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        dir_ew_d = dir_ew_q;
        // Requests latch in every state except WALK, EMRG included.
        ped_d    = ped_q | (io.ped_req && state_q != S_WALK);

        if (io.emerg) begin
            state_d = S_EMRG;
        end else if (state_q == S_EMRG) begin
            state_d  = S_ALL_R;
            timer_d  = CNT_W'(ALLRED_CYC - 1);
            dir_ew_d = 1'b0;
        end else if (!expired) begin
            timer_d = timer_q - 1'b1;
        end else begin
            case (state_q)
                S_NS_G: begin
                    // With no demand, rest here with the timer held at 0.
                    if (io.car_ew || ped_q) begin
                        state_d = S_NS_Y;
                        timer_d = CNT_W'(YELLOW_CYC - 1);
                    end
                end
                S_NS_Y: begin
                    state_d  = S_ALL_R;
                    timer_d  = CNT_W'(ALLRED_CYC - 1);
                    dir_ew_d = 1'b1;
                end
                S_EW_G: begin
                    state_d = S_EW_Y;
                    timer_d = CNT_W'(YELLOW_CYC - 1);
                end
                S_EW_Y: begin
                    state_d  = S_ALL_R;
                    timer_d  = CNT_W'(ALLRED_CYC - 1);
                    dir_ew_d = 1'b0;
                end
                S_ALL_R: begin
                    if (ped_q) begin
                        state_d = S_WALK;
                        timer_d = CNT_W'(PED_CYC - 1);
                        ped_d   = 1'b0;   // clear beats a same-edge set
                    end else begin
                        state_d = dir_ew_q ? S_EW_G : S_NS_G;
                        timer_d = CNT_W'(GREEN_CYC - 1);
                    end
                end
                S_WALK: begin
                    state_d = dir_ew_q ? S_EW_G : S_NS_G;
                    timer_d = CNT_W'(GREEN_CYC - 1);
                end
                default: begin
                    // Illegal code recovers through a clearance phase.
                    state_d = S_ALL_R;
                    timer_d = CNT_W'(ALLRED_CYC - 1);
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_ALL_R;
            timer_q  <= CNT_W'(ALLRED_CYC - 1);
            dir_ew_q <= 1'b0;
            ped_q    <= 1'b0;
            ns_q     <= L_RED;
            ew_q     <= L_RED;
            walk_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            dir_ew_q <= dir_ew_d;
            ped_q    <= ped_d;
            ns_q     <= ns_of(state_d);
            ew_q     <= ew_of(state_d);
            walk_q   <= (state_d == S_WALK);
        end
    end

    assign io.ns_light    = ns_q;
    assign io.ew_light    = ew_q;
    assign io.walk        = walk_q;
    assign io.state       = state_q;
    assign io.ped_pending = ped_q;

endmodule

// File: tb/tb_intersection_controller.sv
module tb_intersection_controller;

    localparam int GREEN  = 8;
    localparam int YELLOW = 2;
    localparam int ALLRED = 1;
    localparam int PED    = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    intersection_controller_if bus ();

    intersection_controller #(
        .GREEN_CYC(GREEN), .YELLOW_CYC(YELLOW), .ALLRED_CYC(ALLRED),
        .PED_CYC(PED), .CNT_W(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .io(bus)
    );

    always #5 clk = ~clk;

    // Reference model: current phase (spec state code), cycles remaining
    // in the phase including the current one, direction owed, request latch.
    int m_phase;
    int m_left;
    bit m_dir_ew;
    bit m_ped;

    function automatic int dur(input int ph);
        case (ph)
            0, 3:    return GREEN;
            1, 4:    return YELLOW;
            5:       return PED;
            default: return ALLRED;
        endcase
    endfunction

    function automatic logic [1:0] exp_ns(input int ph);
        return (ph == 0) ? 2'b10 : (ph == 1) ? 2'b01 : 2'b00;
    endfunction

    function automatic logic [1:0] exp_ew(input int ph);
        return (ph == 3) ? 2'b10 : (ph == 4) ? 2'b01 : 2'b00;
    endfunction

    function automatic logic [8:0] expected();
        return {3'(m_phase), exp_ns(m_phase), exp_ew(m_phase), (m_phase == 5), m_ped};
    endfunction

    function automatic logic [8:0] observed();
        return {bus.state, bus.ns_light, bus.ew_light, bus.walk, bus.ped_pending};
    endfunction

    task automatic enter(input int ph);
        m_phase = ph;
        m_left  = dur(ph);
    endtask

    task automatic model_step(input logic r, input logic c, input logic p, input logic e);
        bit nped;
        if (!r) begin
            enter(2);
            m_dir_ew = 0;
            m_ped    = 0;
            return;
        end
        nped = m_ped | (p && m_phase != 5);
        if (e) begin
            m_phase = 6;
        end else if (m_phase == 6) begin
            enter(2);
            m_dir_ew = 0;
        end else if (m_left > 1) begin
            m_left--;
        end else begin
            case (m_phase)
                0: if (c || m_ped) enter(1);
                1: begin m_dir_ew = 1; enter(2); end
                2: if (m_ped) begin enter(5); nped = 0; end
                   else enter(m_dir_ew ? 3 : 0);
                3: enter(4);
                4: begin m_dir_ew = 0; enter(2); end
                5: enter(m_dir_ew ? 3 : 0);
                default: enter(2);
            endcase
        end
        m_ped = nped;
    endtask

    // Drive one cycle of inputs, advance one edge, step the model.
    task automatic tick(input logic r, input logic c, input logic p, input logic e);
        rst_n       = r;
        bus.car_ew  = c;
        bus.ped_req = p;
        bus.emerg   = e;
        @(posedge clk);
        model_step(r, c, p, e);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 0);
        n_cmp++;
        if (observed() !== 9'({3'd2, 2'b00, 2'b00, 1'b0, 1'b0})) begin
            n_fail++;
            $display("FAIL reset_state: got %b want %b", observed(), 9'({3'd2, 4'b0, 2'b0}));
        end
        tick(1, 0, 0, 0);
        n_cmp++;
        if (bus.state !== 3'd0 || bus.ns_light !== 2'b10 || bus.ew_light !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_release: got state %0d ns %b ew %b want state 0 ns 10 ew 00",
                     bus.state, bus.ns_light, bus.ew_light);
        end
    endtask

    task automatic test_rest_ns();
        int bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1, 0, 0, 0);
            if (bus.state !== 3'd0 || bus.ns_light !== 2'b10 || bus.ew_light !== 2'b00) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL rest_ns: %0d cycles off NS green, want 0", bad);
        end
    endtask

    task automatic test_full_cycle();
        int ns_g = 0, ew_g = 0, both = 0, diff = 0;
        tick(0, 0, 0, 0);
        for (int i = 0; i < 30; i++) begin
            tick(1, 1, 0, 0);
            if (bus.ns_light == 2'b10) ns_g++;
            if (bus.ew_light == 2'b10) ew_g++;
            if (bus.ns_light != 2'b00 && bus.ew_light != 2'b00) both++;
            if (observed() !== expected()) diff++;
        end
        n_cmp++;
        if (ns_g != 2 * GREEN || ew_g != GREEN) begin
            n_fail++;
            $display("FAIL full_cycle_greens: got ns %0d ew %0d want ns %0d ew %0d",
                     ns_g, ew_g, 2 * GREEN, GREEN);
        end
        n_cmp++;
        if (both != 0 || diff != 0) begin
            n_fail++;
            $display("FAIL full_cycle_seq: conflicts %0d model diffs %0d want 0/0", both, diff);
        end
    endtask

    task automatic test_pedestrian();
        int walks = 0, guard = 0, diff = 0;
        while (m_phase != 3 && guard < 40) begin tick(1, 1, 0, 0); guard++; end
        n_cmp++;
        if (guard >= 40) begin
            n_fail++;
            $display("FAIL ped_reach_ewg: timeout, state %0d want 3", bus.state);
        end
        tick(1, 0, 1, 0);
        n_cmp++;
        if (bus.ped_pending !== 1'b1) begin
            n_fail++;
            $display("FAIL ped_latch: got %b want 1", bus.ped_pending);
        end
        for (int i = 0; i < 20; i++) begin
            tick(1, 0, 0, 0);
            if (bus.walk === 1'b1) begin
                walks++;
                if (bus.ns_light !== 2'b00 || bus.ew_light !== 2'b00 || bus.ped_pending !== 1'b0) diff++;
            end
            if (observed() !== expected()) diff++;
        end
        n_cmp++;
        if (walks != PED || diff != 0) begin
            n_fail++;
            $display("FAIL ped_walk: walk cycles %0d want %0d, diffs %0d want 0", walks, PED, diff);
        end
        n_cmp++;
        if (bus.state !== 3'd0) begin
            n_fail++;
            $display("FAIL ped_after: got state %0d want 0", bus.state);
        end
    endtask

    task automatic test_emergency();
        int guard = 0, emrg = 0, walks = 0, diff = 0;
        while (m_phase != 1 && guard < 40) begin tick(1, 1, 0, 0); guard++; end
        tick(1, 0, 0, 0);   // second NS_Y cycle
        for (int i = 0; i < 5; i++) begin
            tick(1, 0, (i == 2), 1);
            if (bus.state === 3'd6 && bus.ns_light === 2'b00 && bus.ew_light === 2'b00) emrg++;
        end
        n_cmp++;
        if (emrg != 5 || bus.ped_pending !== 1'b1) begin
            n_fail++;
            $display("FAIL emerg_hold: EMRG cycles %0d want 5, ped %b want 1", emrg, bus.ped_pending);
        end
        tick(1, 0, 0, 0);
        n_cmp++;
        if (bus.state !== 3'd2) begin
            n_fail++;
            $display("FAIL emerg_release: got state %0d want 2", bus.state);
        end
        for (int i = 0; i < 5; i++) begin
            tick(1, 0, 0, 0);
            if (bus.walk === 1'b1) walks++;
            if (observed() !== expected()) diff++;
        end
        n_cmp++;
        if (walks != PED || bus.state !== 3'd0 || diff != 0) begin
            n_fail++;
            $display("FAIL emerg_walk: walk %0d want %0d, state %0d want 0, diffs %0d",
                     walks, PED, bus.state, diff);
        end
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        while (m_phase != 3 && guard < 40) begin tick(1, 1, 0, 0); guard++; end
        tick(1, 0, 1, 0);
        tick(0, 0, 0, 0);
        n_cmp++;
        if (observed() !== 9'({3'd2, 4'b0000, 1'b0, 1'b0})) begin
            n_fail++;
            $display("FAIL reset_mid: got %b want %b", observed(), 9'({3'd2, 6'b0}));
        end
        tick(1, 0, 0, 0);
        n_cmp++;
        if (bus.state !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_mid_after: got state %0d want 0", bus.state);
        end
    endtask

    task automatic test_random();
        int diff = 0, both = 0, first = -1;
        logic [8:0] fo = '0, fe = '0;
        logic r, c, p, e;
        c = 0;
        for (int i = 0; i < 2000; i++) begin
            r = ($urandom_range(199) != 0);
            if ($urandom_range(5) == 0) c = ~c;
            p = ($urandom_range(7) == 0);
            e = ($urandom_range(29) == 0) || (bus.state == 3'd6 && $urandom_range(2) != 0);
            tick(r, c, p, e);
            if (bus.ns_light != 2'b00 && bus.ew_light != 2'b00) both++;
            if (observed() !== expected()) begin
                if (first < 0) begin first = i; fo = observed(); fe = expected(); end
                diff++;
            end
        end
        n_cmp++;
        if (diff != 0) begin
            n_fail++;
            $display("FAIL random_model: %0d diffs, first at %0d got %b want %b", diff, first, fo, fe);
        end
        n_cmp++;
        if (both != 0) begin
            n_fail++;
            $display("FAIL random_conflict: %0d cycles both non-red, want 0", both);
        end
    endtask

    initial begin
        bus.car_ew  = 0;
        bus.ped_req = 0;
        bus.emerg   = 0;
        m_phase = 2; m_left = ALLRED; m_dir_ew = 0; m_ped = 0;
        test_reset();
        test_rest_ns();
        test_full_cycle();
        test_pedestrian();
        test_emergency();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
